// File: rtl/booth_pkg.sv
// booth_pkg: shared types and constants for the radix-2 Booth multiplier
// control slice.
//   state_e     - controller state encoding (IDLE, LOAD, ADD, SHIFT, DONE)
//   SEL_ADD/SUB - add/sub unit select encodings driven on the sel port
//   BOOTH_WIDTH - default operand width (number of Booth iterations)
// Optional feature macro used by this slice: BOOTH_SKIP_IDLE_ITER_EN
`timescale 1ns/1ps
package booth_pkg;

  localparam int BOOTH_WIDTH = 4;

  localparam logic SEL_ADD = 1'b0;
  localparam logic SEL_SUB = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/booth_iter_counter.sv
// booth_iter_counter: counts completed Booth iterations.
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset (count -> 0)
//   clear - synchronous clear (used in LOAD)
//   inc   - advance by one (asserted on the shift of each iteration)
//   last  - high while the count equals WIDTH-1, i.e. the current
//           iteration is the final one
`timescale 1ns/1ps
module booth_iter_counter
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic last
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] count_r;

  // Iteration count register: reset/clear take priority over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (inc) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign last = (count_r == LAST_CNT);

endmodule

// File: rtl/booth_control_unit.sv
// booth_control_unit: sequencing FSM for a radix-2 Booth multiplier datapath.
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset (aborts any operation)
//   start    - begin a multiplication; only honoured in IDLE
//   q0, q1   - datapath feedback: multiplier LSB and Q(-1)
//   load_a   - load multiplicand register        (LOAD only)
//   load_b   - load LQ with the multiplier       (LOAD only)
//   clr_acc  - clear HQ and Q(-1)                (LOAD only)
//   load_add - write add/sub result into HQ      (ADD, q0 != q1)
//   sel      - 0: HQ + M, 1: HQ - M
//   shift    - arithmetic right shift of {HQ, LQ, Q(-1)}
//   busy     - high from LOAD through the final shift
//   done     - one-cycle pulse, product valid on the datapath
// WIDTH must be >= 2.
// Optional macro BOOTH_SKIP_IDLE_ITER_EN: iterations with q0 == q1 shift
// directly from ADD instead of spending a cycle in SHIFT.
`timescale 1ns/1ps
module booth_control_unit
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic q0,
  input  logic q1,
  output logic load_a,
  output logic load_b,
  output logic clr_acc,
  output logic load_add,
  output logic sel,
  output logic shift,
  output logic busy,
  output logic done
);

  state_e state_r;
  state_e next_state_s;
  logic   last_s;
  logic   skip_s;

  // An iteration with q0 == q1 needs no add/sub, only the shift.
`ifdef BOOTH_SKIP_IDLE_ITER_EN
  assign skip_s = (q0 == q1);
`else
  assign skip_s = 1'b0;
`endif

  booth_iter_counter #(
    .WIDTH (WIDTH)
  ) u_iter_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (load_a),
    .inc   (shift),
    .last  (last_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; start outside IDLE is deliberately ignored.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = LOAD;
        end else begin
          next_state_s = IDLE;
        end
      end
      LOAD: begin
        next_state_s = ADD;
      end
      ADD: begin
        if (skip_s) begin
          // Shift already happened in this cycle; last refers to the
          // pre-increment count, so this was the final iteration.
          if (last_s) begin
            next_state_s = DONE;
          end else begin
            next_state_s = ADD;
          end
        end else begin
          next_state_s = SHIFT;
        end
      end
      SHIFT: begin
        if (last_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = ADD;
        end
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Output decode: Moore except load_add/sel, which follow {q0,q1} in ADD.
  always_comb begin
    load_a   = 1'b0;
    load_b   = 1'b0;
    clr_acc  = 1'b0;
    load_add = 1'b0;
    sel      = SEL_ADD;
    shift    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_r)
      IDLE: begin
        busy = 1'b0;
      end
      LOAD: begin
        load_a  = 1'b1;
        load_b  = 1'b1;
        clr_acc = 1'b1;
        busy    = 1'b1;
      end
      ADD: begin
        busy = 1'b1;
        case ({q0, q1})
          2'b10: begin
            load_add = 1'b1;
            sel      = SEL_SUB;
          end
          2'b01: begin
            load_add = 1'b1;
            sel      = SEL_ADD;
          end
          default: begin
            load_add = 1'b0;
            sel      = SEL_ADD;
            shift    = skip_s;
          end
        endcase
      end
      SHIFT: begin
        shift = 1'b1;
        busy  = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule
